// File: rtl/dcache_wb_buffer.sv
// Write-back victim buffer: queues dirty lines from the D-cache and drains each one
// as a single-address, four-beat write burst, while keeping queued lines visible to refills.
module dcache_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         evict_valid_i,
    output logic         evict_ready_o,
    input  logic [27:0]  evict_addr_i,
    input  logic [127:0] evict_data_i,
    input  logic [27:0]  lk_addr_i,
    output logic         lk_hit_o,
    output logic [127:0] lk_data_o,
    output logic         mem_awvalid_o,
    input  logic         mem_awready_i,
    output logic [31:0]  mem_awaddr_o,
    output logic         mem_wvalid_o,
    input  logic         mem_wready_i,
    output logic [31:0]  mem_wdata_o,
    output logic         mem_wlast_o,
    input  logic         mem_bvalid_i,
    output logic         buf_empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    state_e          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [27:0]     addr_q [DEPTH];
    logic [127:0]    data_q [DEPTH];

    logic            push;
    logic            pop;
    logic [PtrW-1:0] lk_idx;

    assign evict_ready_o = (count_q != CntW'(DEPTH));
    assign push          = evict_valid_i && evict_ready_o;
    assign pop           = (state_q == StB) && mem_bvalid_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            beat_q   <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Line storage carries no reset; occupancy is defined solely by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= evict_addr_i;
            data_q[wr_ptr_q] <= evict_data_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StAw;
            end
            StAw: begin
                if (mem_awready_i) state_d = StW;
            end
            StW: begin
                if (mem_wready_i) begin
                    if (beat_q == 2'd3) begin
                        state_d = StB;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            StB: begin
                if (mem_bvalid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // Output logic
    always_comb begin
        mem_awvalid_o = (state_q == StAw);
        mem_awaddr_o  = '0;
        mem_wvalid_o  = (state_q == StW);
        mem_wdata_o   = '0;
        mem_wlast_o   = (state_q == StW) && (beat_q == 2'd3);
        buf_empty_o   = (count_q == '0) && (state_q == StIdle);
        if (state_q == StAw) mem_awaddr_o = {addr_q[rd_ptr_q], 4'h0};
        if (state_q == StW)  mem_wdata_o  = data_q[rd_ptr_q][{beat_q, 5'd0} +: 32];
    end

    // Walk oldest to youngest so the last match (nearest wr_ptr) wins.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_data_o = '0;
        lk_idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (addr_q[lk_idx] == lk_addr_i)) begin
                lk_hit_o  = 1'b1;
                lk_data_o = data_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus a random phase, all checked against a
// queue-of-lines model and an expected memory write trace.
module tb_dcache_wb_buffer;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         evict_valid;
    logic         evict_ready;
    logic [27:0]  evict_addr;
    logic [127:0] evict_data;
    logic [27:0]  lk_addr;
    logic         lk_hit;
    logic [127:0] lk_data;
    logic         mem_awvalid;
    logic         mem_awready;
    logic [31:0]  mem_awaddr;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [31:0]  mem_wdata;
    logic         mem_wlast;
    logic         mem_bvalid;
    logic         buf_empty;

    dcache_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .evict_valid_i(evict_valid),
        .evict_ready_o(evict_ready),
        .evict_addr_i (evict_addr),
        .evict_data_i (evict_data),
        .lk_addr_i    (lk_addr),
        .lk_hit_o     (lk_hit),
        .lk_data_o    (lk_data),
        .mem_awvalid_o(mem_awvalid),
        .mem_awready_i(mem_awready),
        .mem_awaddr_o (mem_awaddr),
        .mem_wvalid_o (mem_wvalid),
        .mem_wready_i (mem_wready),
        .mem_wdata_o  (mem_wdata),
        .mem_wlast_o  (mem_wlast),
        .mem_bvalid_i (mem_bvalid),
        .buf_empty_o  (buf_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0]  addr;
        logic [127:0] data;
    } line_t;

    line_t       q[$];
    logic [31:0] aw_log[$];
    logic [31:0] beat_log[$];
    bit          aw_done;
    int          beats_done;
    bit          pushed;
    bit          auto_b;
    int          n_pops;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    function automatic bit head_in_b();
        return (q.size() > 0) && aw_done && (beats_done == 4);
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then step past the rise.
    task automatic tick();
        bit           exp_hit;
        logic [127:0] exp_dat;
        logic [127:0] d;
        bit           pop;
        @(negedge clk);
        pushed = 1'b0;
        if (rst) begin
            q.delete();
            aw_done    = 1'b0;
            beats_done = 0;
        end else begin
            exp_hit = 1'b0;
            exp_dat = '0;
            foreach (q[i]) begin
                if (q[i].addr == lk_addr) begin
                    exp_hit = 1'b1;
                    exp_dat = q[i].data;
                end
            end
            check("evict_ready", evict_ready, q.size() != DEPTH);
            check("buf_empty", buf_empty, q.size() == 0);
            check("lk_hit", lk_hit, exp_hit);
            check("lk_data", lk_data, exp_dat);
            if (q.size() == 0 || aw_done) check("awvalid_off", mem_awvalid, 1'b0);
            if (mem_awvalid && !aw_done && q.size() > 0)
                check("awaddr", mem_awaddr, {q[0].addr, 4'h0});
            if (!aw_done || beats_done == 4) check("wvalid_off", mem_wvalid, 1'b0);
            if (mem_wvalid && aw_done && beats_done < 4) begin
                d = q[0].data >> (32 * beats_done);
                check("wdata", mem_wdata, d[31:0]);
                check("wlast", mem_wlast, beats_done == 3);
            end
            pop    = mem_bvalid && head_in_b();
            pushed = evict_valid && (q.size() != DEPTH);
            if (mem_wvalid && mem_wready && aw_done && beats_done < 4) begin
                beat_log.push_back(mem_wdata);
                beats_done++;
            end
            if (mem_awvalid && mem_awready && !aw_done && q.size() > 0) begin
                aw_log.push_back(mem_awaddr);
                aw_done = 1'b1;
            end
            if (pop) begin
                void'(q.pop_front());
                aw_done    = 1'b0;
                beats_done = 0;
                n_pops++;
            end
            if (pushed) q.push_back('{addr: evict_addr, data: evict_data});
        end
        @(posedge clk);
        #1;
        if (auto_b) mem_bvalid = head_in_b();
    endtask

    task automatic push_line(input logic [27:0] a, input logic [127:0] d);
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (pushed) break;
        end
        if (!pushed) timeout("push");
        evict_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        if (q.size() != 0) timeout("drain");
        tick();
    endtask

    task automatic wait_b();
        for (int k = 0; k < 200; k++) begin
            if (head_in_b()) break;
            tick();
        end
        if (!head_in_b()) timeout("wait_b");
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed time limit expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] la, lb, lx;
        rst = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0; lk_addr = '0;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0;
        auto_b = 1'b1; aw_done = 1'b0; beats_done = 0; n_pops = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_evict_ready", evict_ready, 1'b1);
        check("rst_awvalid", mem_awvalid, 1'b0);
        check("rst_wvalid", mem_wvalid, 1'b0);
        check("rst_wlast", mem_wlast, 1'b0);
        check("rst_awaddr", mem_awaddr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_lk_hit", lk_hit, 1'b0);
        check("rst_lk_data", lk_data, 128'h0);
        check("rst_buf_empty", buf_empty, 1'b1);
        rst = 1'b0;

        // Single line, memory always ready
        mem_awready = 1'b1; mem_wready = 1'b1;
        aw_log.delete(); beat_log.delete();
        push_line(28'h0000123, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        drain();
        check("single_aw_count", aw_log.size(), 1);
        check("single_awaddr", aw_log[0], 32'h00001230);
        check("single_beats", beat_log.size(), 4);
        check("single_beat0", beat_log[0], 32'h11111111);
        check("single_beat1", beat_log[1], 32'h22222222);
        check("single_beat2", beat_log[2], 32'h33333333);
        check("single_beat3", beat_log[3], 32'h44444444);

        // Fill while memory stalls on AW, fifth line waits for a pop
        mem_awready = 1'b0;
        for (int i = 0; i < 4; i++) push_line(28'h0000200 + 28'(i), rnd128());
        tick();
        check("full_ready", evict_ready, 1'b0);
        evict_valid = 1'b1; evict_addr = 28'h0000204; evict_data = rnd128();
        n_pops = 0;
        repeat (3) tick();
        check("held_pops", n_pops, 0);
        mem_awready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (pushed) break;
        end
        check("fifth_after_pop", n_pops, 1);
        evict_valid = 1'b0;
        drain();

        // Duplicate address: lookup returns the youngest copy, both copies written
        mem_awready = 1'b0;
        aw_log.delete(); beat_log.delete();
        la = {4{32'hAAAA0001}};
        lb = {4{32'hBBBB0002}};
        push_line(28'h0000ABC, la);
        push_line(28'h0000ABC, lb);
        lk_addr = 28'h0000ABC;
        tick();
        check("dup_hit", lk_hit, 1'b1);
        check("dup_data", lk_data, lb);
        mem_awready = 1'b1;
        drain();
        check("dup_after_hit", lk_hit, 1'b0);
        check("dup_aw_count", aw_log.size(), 2);
        check("dup_first", beat_log[0], 32'hAAAA0001);
        check("dup_second", beat_log[4], 32'hBBBB0002);

        // Write channel stalls every other cycle
        aw_log.delete(); beat_log.delete();
        push_line(28'h0000777, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});
        for (int k = 0; k < 100 && q.size() != 0; k++) begin
            mem_wready = ~mem_wready;
            tick();
        end
        mem_wready = 1'b1;
        drain();
        check("toggle_beats", beat_log.size(), 4);
        check("toggle_beat0", beat_log[0], 32'hA0A0A0A0);
        check("toggle_beat3", beat_log[3], 32'hD3D3D3D3);

        // Push coinciding with pop: refused when full, accepted at count 3
        auto_b = 1'b0; mem_bvalid = 1'b0;
        aw_log.delete();
        for (int i = 0; i < 4; i++) push_line(28'h0000300 + 28'(i), rnd128());
        wait_b();
        check("full_count", q.size(), 4);
        evict_valid = 1'b1; evict_addr = 28'h0000304; evict_data = rnd128();
        mem_bvalid = 1'b1;
        tick();
        check("full_pop_refused", pushed, 1'b0);
        mem_bvalid = 1'b0; evict_valid = 1'b0;
        wait_b();
        check("three_count", q.size(), 3);
        evict_valid = 1'b1; mem_bvalid = 1'b1;
        tick();
        check("three_pop_accepted", pushed, 1'b1);
        mem_bvalid = 1'b0; evict_valid = 1'b0;
        tick();
        check("three_ready", evict_ready, 1'b1);
        auto_b = 1'b1;
        drain();
        check("pp_aw_count", aw_log.size(), 5);
        check("pp_aw_last", aw_log[4], 32'h00003040);

        // Reset in the middle of a burst
        lx = rnd128();
        push_line(28'h0000555, lx);
        auto_b = 1'b0;
        for (int k = 0; k < 50 && beats_done < 2; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_wvalid", mem_wvalid, 1'b0);
        check("rst_mid_empty", buf_empty, 1'b1);
        check("rst_mid_ready", evict_ready, 1'b1);
        mem_bvalid = 1'b1;
        repeat (3) tick();
        check("rst_mid_awvalid", mem_awvalid, 1'b0);
        check("rst_mid_after_b", buf_empty, 1'b1);
        mem_bvalid = 1'b0;

        // Random traffic with stray write responses
        for (int n = 0; n < 1500; n++) begin
            evict_valid = ($urandom_range(0, 2) == 0);
            evict_addr  = 28'h0000010 + 28'($urandom_range(0, 5));
            evict_data  = rnd128();
            lk_addr     = 28'h0000010 + 28'($urandom_range(0, 6));
            mem_awready = ($urandom_range(0, 3) != 0);
            mem_wready  = ($urandom_range(0, 3) != 0);
            mem_bvalid  = ($urandom_range(0, 2) == 0);
            tick();
        end
        evict_valid = 1'b0; mem_awready = 1'b1; mem_wready = 1'b1; auto_b = 1'b1;
        mem_bvalid = head_in_b();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_wb_buffer.md
DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered victim lines (power of 2, >=2).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 evict_valid  input  1  controller presents a dirty victim line.
REQ-005 evict_ready  output  1  buffer accepts the victim line this cycle.
REQ-006 evict_addr  input  28  victim line address (byte address [31:4]).
REQ-007 evict_data  input  128  victim line data, word0 = bits [31:0].
REQ-008 lk_addr  input  28  refill lookup line address.
REQ-009 lk_hit  output  1  lk_addr matches a buffered line (combinational).
REQ-010 lk_data  output  128  data of youngest matching entry, 0 on miss.
REQ-011 mem_awvalid  output  1  write-burst address valid.
REQ-012 mem_awready  input  1  memory accepts address.
REQ-013 mem_awaddr  output  32  burst byte address {addr, 4'b0}.
REQ-014 mem_wvalid  output  1  write beat valid.
REQ-015 mem_wready  input  1  memory accepts beat.
REQ-016 mem_wdata  output  32  beat data.
REQ-017 mem_wlast  output  1  final (4th) beat of burst.
REQ-018 mem_bvalid  input  1  write response; buffer always accepts.
REQ-019 buf_empty  output  1  no entries held and FSM in IDLE.

Function
REQ-020 Storage SHALL be a circular FIFO of DEPTH entries {addr 28, data 128}, wr_ptr, rd_ptr, count (log2(DEPTH)+1 bits).
REQ-021 evict_ready SHALL equal (count != DEPTH), independent of same-cycle pop.
REQ-022 Push SHALL occur on evict_valid && evict_ready: entry[wr_ptr] written, wr_ptr+1 modulo DEPTH.
REQ-023 Drain FSM states IDLE, AW, W, B; IDLE->AW when count != 0, entry taken from rd_ptr.
REQ-024 AW: mem_awvalid=1, mem_awaddr={entry.addr,4'b0}; AW->W on mem_awready.
REQ-025 W: beat counter 0..3, mem_wvalid=1, mem_wdata = entry.data[32*beat+31 : 32*beat]; beat advances only on mem_wready; mem_wlast=1 when beat==3.
REQ-026 W->B on mem_wready && mem_wlast; beat counter returns to 0.
REQ-027 B: wait for mem_bvalid; on it pop (rd_ptr+1 modulo DEPTH), go IDLE; mem_bvalid outside B SHALL be ignored.
REQ-028 AW/W outputs SHALL hold stable while valid and not ready.
REQ-029 Entry being drained SHALL remain visible to lookup until popped in B.
REQ-030 Simultaneous push and pop SHALL leave count unchanged, both pointers advance.
REQ-031 Lookup SHALL compare lk_addr against all occupied entries; multiple matches resolve to entry nearest wr_ptr (youngest).
REQ-032 Duplicate addresses SHALL each be written to memory in FIFO order; no coalescing.
REQ-033 Pointer wrap-around SHALL be modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-034 buf_empty SHALL be 1 only when count==0 and FSM in IDLE.

Reset
REQ-035 On rst: count, wr_ptr, rd_ptr, beat = 0, FSM = IDLE, all entries invalid.
REQ-036 Reset outputs: evict_ready=1, mem_awvalid=0, mem_wvalid=0, mem_wlast=0, mem_awaddr=0, mem_wdata=0, lk_hit=0, lk_data=0, buf_empty=1.
REQ-037 rst mid-burst SHALL abandon burst and drop all buffered lines; no further beats issued.

Verification
REQ-038 Single push addr=28'h0000123, data=128'h44..._33..._22..._11... with ready tied 1 -> awaddr=32'h00001230, 4 beats 0x11111111,0x22222222,0x33333333,0x44444444, wlast on beat4, buf_empty=1 one cycle after bvalid.
REQ-039 Push 4 lines, memory stalled (awready=0) -> evict_ready=0 after 4th push, 5th evict held; after one bvalid evict_ready=1 and 5th accepted.
REQ-040 Push addr 0x0000ABC twice with data A then B, lk_addr=0x0000ABC -> lk_hit=1, lk_data=B; after both drained lk_hit=0.
REQ-041 mem_wready toggled 1,0,1,0... -> each beat held stable while stalled, exactly 4 accepted beats, order preserved.
REQ-042 Push on same cycle as pop with count=4 -> push refused; with count=3 -> accepted, count stays 3.
REQ-043 rst asserted after beat 2 of a burst -> next cycle mem_wvalid=0, buf_empty=1, evict_ready=1, no response to later bvalid.
